audio_i2s_tx: RTL and testbench
===============================

// Module: audio_i2s_tx
// PURPOSE
//  Sink stage after fm_radio: pops paired left/right audio words from the two output FIFOs (first-word-fall-through)
//  and drives a continuous Philips I2S stream (bclk/lrclk/sdata) to an external DAC.
//  Each word is shifted and saturated to SAMPLE_BITS. Frames with no data are sent as zeros and counted as underruns.
// PARAMETERS
//  DATA_SIZE    32  width of left/right audio words from fm_radio (signed)
//  SAMPLE_BITS  16  bits per channel on the I2S line; frame = 2*SAMPLE_BITS bclk periods
//  SHIFT        0   arithmetic right shift applied before saturation
//  BCLK_DIV     2   clock cycles per bclk half-period (>=1)
// PORTS
//  clock              in   1            system clock
//  reset              in   1            asynchronous, active-low
//  left_audio_in      in   DATA_SIZE    left FIFO head word, valid while left_audio_empty=0
//  left_audio_empty   in   1            left FIFO empty
//  left_audio_rd_en   out  1            left FIFO pop, 1-cycle pulse
//  right_audio_in     in   DATA_SIZE    right FIFO head word
//  right_audio_empty  in   1            right FIFO empty
//  right_audio_rd_en  out  1            right FIFO pop, 1-cycle pulse, always equal to left_audio_rd_en
//  bclk               out  1            I2S bit clock
//  lrclk              out  1            I2S word select: 0=left, 1=right
//  sdata              out  1            I2S serial data, MSB first
//  underrun_count     out  16           saturating count of zero-filled frames
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; holding register empty (nxt_valid=0); divider and bit counter 0.
//  Fetch: rd_en <= ~rd_en & ~nxt_valid & ~left_empty & ~right_empty. Both FIFOs are popped together, never one alone.
//   On the edge where rd_en=1, nxt_L/nxt_R capture sat(in>>>SHIFT) and nxt_valid is set.
//   Capture-to-pop latency is 1 cycle. Holding depth is exactly one pair.
//  sat(x): clamp to [-2^(SAMPLE_BITS-1), 2^(SAMPLE_BITS-1)-1]; otherwise take the low SAMPLE_BITS bits.
//  FSM:
//   IDLE: bclk held 0, no frames sent.
//    Moves to RUN when nxt_valid=1: load shreg <= {nxt_L,nxt_R}, clear nxt_valid, bit_cnt=0.
//   RUN: div_cnt counts 0..BCLK_DIV-1. bclk toggles when div_cnt wraps.
//    Each falling bclk edge advances bit_cnt and shifts shreg left by 1.
//    sdata = shreg MSB; sdata and lrclk change only at falling edges.
//    lrclk = 1 for bit_cnt in [SAMPLE_BITS-1, 2*SAMPLE_BITS-2], else 0. This gives the standard 1-bit I2S delay.
//    Frame boundary = falling edge where bit_cnt wraps 2*SAMPLE_BITS-1 -> 0.
//     If nxt_valid=1: shreg <= {nxt_L,nxt_R}, nxt_valid <= 0.
//     Else: shreg <= 0, underrun_count++ (sticks at 16'hFFFF).
//    RUN never returns to IDLE except through reset.
//  Simultaneous events: a capture on the same edge as a frame boundary with nxt_valid=0 counts as an underrun.
//   The captured pair is sent in the following frame.
//  Reset mid-frame: asynchronous. All outputs drop to 0 immediately; the partial frame is discarded.
//   FIFO contents are untouched apart from pops already completed.
// CONFIGURATION
//  I2S_TX_MONO_EN defined: at capture, nxt_L = nxt_R = sat(((L+R)>>>1)>>>SHIFT), using a DATA_SIZE+1 bit sum.
//  I2S_TX_MONO_EN undefined: left and right are independent (the default stereo path).
// STRUCTURE
//  globals package: I2S_SAMPLE_BITS, I2S_BCLK_DIV constants; typedef enum logic {IDLE,RUN} i2s_state_t.
//  Sub-module audio_saturate (combinational shift + clamp, params DATA_SIZE/SAMPLE_BITS/SHIFT), instantiated once per channel.
//  The FSM, divider, counters and shift register all live in audio_i2s_tx.
// TESTING (SAMPLE_BITS=16, BCLK_DIV=2 -> bclk period 4 clocks, frame 128 clocks)
//  1 L=32'h00001234, R=32'hFFFFEDCC.
//    -> Single pop. lrclk falls, then sdata shifts 0x1234 MSB-first one bclk later.
//    -> lrclk rises, then 0xEDCC follows.
//  2 L=32'h00012345, R=32'hFFF00000.
//    -> Transmitted words are 0x7FFF and 0x8000 (saturation).
//  3 One pair supplied, then FIFOs left empty for 3 frames.
//    -> 3 all-zero frames; underrun_count=3; lrclk keeps toggling every 64 clocks.
//  4 FIFOs hold 10 pairs.
//    -> Exactly 10 rd_en pulses, one per frame and never back-to-back.
//    -> left/right rd_en are identical; no underrun while data lasts.
//  5 reset asserted at bit 7 of the left word.
//    -> bclk/lrclk/sdata/rd_en/underrun_count are 0 in the same time step.
//    -> After release, IDLE holds until the next pair arrives.
//  6 With I2S_TX_MONO_EN: L=1000, R=3000.
//    -> Both slots carry 2000 (0x07D0).

Source files
------------

// File: rtl/audio_i2s_tx_pkg.sv
// Shared constants and state type for the I2S transmitter.
// The optional mono down-mix is selected with the I2S_TX_MONO_EN macro.
package audio_i2s_tx_pkg;

  localparam int I2S_SAMPLE_BITS = 16;
  localparam int I2S_BCLK_DIV    = 2;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } i2s_state_t;

endpackage

// File: rtl/audio_i2s_tx_saturate.sv
// Arithmetic right shift followed by a clamp to a signed SAMPLE_BITS range.
// Values that already fit are passed through as their low SAMPLE_BITS bits.
module audio_saturate #(
  parameter int DATA_SIZE   = 32,
  parameter int SAMPLE_BITS = 16,
  parameter int SHIFT       = 0
) (
  input  logic signed [DATA_SIZE-1:0]   word,
  output logic        [SAMPLE_BITS-1:0] sample
);

  logic signed [DATA_SIZE-1:0] shifted;
  logic                        fits;

  assign shifted = word >>> SHIFT;

  // The value fits when every bit above the sample sign bit copies the word sign.
  assign fits = (shifted[DATA_SIZE-1:SAMPLE_BITS-1] ==
                 {(DATA_SIZE-SAMPLE_BITS+1){shifted[DATA_SIZE-1]}});

  always_comb begin
    sample = shifted[SAMPLE_BITS-1:0];
    if (!fits) begin
      if (shifted[DATA_SIZE-1]) sample = {1'b1, {(SAMPLE_BITS-1){1'b0}}};
      else                      sample = {1'b0, {(SAMPLE_BITS-1){1'b1}}};
    end
  end

endmodule

// File: rtl/audio_i2s_tx.sv
// Philips I2S transmitter fed from paired left/right FWFT FIFOs, with one-pair holding register.
// Defining I2S_TX_MONO_EN sends the saturated average of left and right on both slots.
module audio_i2s_tx
  import audio_i2s_tx_pkg::*;
#(
  parameter int DATA_SIZE   = 32,
  parameter int SAMPLE_BITS = I2S_SAMPLE_BITS,
  parameter int SHIFT       = 0,
  parameter int BCLK_DIV    = I2S_BCLK_DIV
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [DATA_SIZE-1:0] left_audio_in,
  input  logic                 left_audio_empty,
  output logic                 left_audio_rd_en,
  input  logic [DATA_SIZE-1:0] right_audio_in,
  input  logic                 right_audio_empty,
  output logic                 right_audio_rd_en,
  output logic                 bclk,
  output logic                 lrclk,
  output logic                 sdata,
  output logic [15:0]          underrun_count,
  output i2s_state_t           fsm_state
);

  localparam int FRAME_BITS = 2 * SAMPLE_BITS;
  localparam int CNT_W      = $clog2(FRAME_BITS);
  localparam int DIV_W      = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_BITS - 1);
  localparam logic [CNT_W-1:0] LR_FIRST = CNT_W'(SAMPLE_BITS - 1);
  localparam logic [CNT_W-1:0] LR_LAST  = CNT_W'(FRAME_BITS - 2);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);

  i2s_state_t             state, state_next;
  logic                   pop, nxt_valid, load, bclk_fall, frame_end;
  logic [SAMPLE_BITS-1:0] nxt_l, nxt_r, sat_l, sat_r;
  logic [FRAME_BITS-1:0]  shreg;
  logic [DIV_W-1:0]       div_cnt;
  logic [CNT_W-1:0]       bit_cnt;
  logic [DATA_SIZE-1:0]   left_word, right_word;

`ifdef I2S_TX_MONO_EN
  logic [DATA_SIZE:0] mono_sum;
  assign mono_sum   = {left_audio_in[DATA_SIZE-1], left_audio_in}
                    + {right_audio_in[DATA_SIZE-1], right_audio_in};
  assign left_word  = DATA_SIZE'(mono_sum >> 1);
  assign right_word = DATA_SIZE'(mono_sum >> 1);
`else
  assign left_word  = left_audio_in;
  assign right_word = right_audio_in;
`endif

  audio_saturate #(.DATA_SIZE(DATA_SIZE), .SAMPLE_BITS(SAMPLE_BITS), .SHIFT(SHIFT))
    u_sat_left  (.word(left_word),  .sample(sat_l));
  audio_saturate #(.DATA_SIZE(DATA_SIZE), .SAMPLE_BITS(SAMPLE_BITS), .SHIFT(SHIFT))
    u_sat_right (.word(right_word), .sample(sat_r));

  assign left_audio_rd_en  = pop;
  assign right_audio_rd_en = pop;
  assign fsm_state         = state;
  assign sdata             = shreg[FRAME_BITS-1];
  // Word select leads the data by one bit, giving the standard I2S delay.
  assign lrclk             = (bit_cnt >= LR_FIRST) && (bit_cnt <= LR_LAST);
  assign bclk_fall         = (state == RUN) && bclk && (div_cnt == DIV_LAST);
  assign frame_end         = bclk_fall && (bit_cnt == CNT_LAST);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    load       = 1'b0;
    case (state)
      IDLE: begin
        if (nxt_valid) begin
          state_next = RUN;
          load       = 1'b1;
        end
      end
      RUN:     load = frame_end && nxt_valid;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pop            <= 1'b0;
      nxt_valid      <= 1'b0;
      nxt_l          <= '0;
      nxt_r          <= '0;
      shreg          <= '0;
      div_cnt        <= '0;
      bit_cnt        <= '0;
      bclk           <= 1'b0;
      underrun_count <= '0;
    end else begin
      pop <= ~pop & ~nxt_valid & ~left_audio_empty & ~right_audio_empty;
      if (pop) begin
        nxt_l     <= sat_l;
        nxt_r     <= sat_r;
        nxt_valid <= 1'b1;
      end else if (load) begin
        nxt_valid <= 1'b0;
      end
      if (load) shreg <= {nxt_l, nxt_r};

      if (state == IDLE) begin
        div_cnt <= '0;
        bit_cnt <= '0;
        bclk    <= 1'b0;
      end else begin
        if (div_cnt == DIV_LAST) begin
          div_cnt <= '0;
          bclk    <= ~bclk;
        end else begin
          div_cnt <= div_cnt + 1'b1;
        end
        if (bclk_fall) begin
          if (bit_cnt == CNT_LAST) begin
            bit_cnt <= '0;
            // A pair captured on this very edge is not yet valid and goes out next frame.
            if (!nxt_valid) begin
              shreg <= '0;
              if (underrun_count != 16'hFFFF) underrun_count <= underrun_count + 16'd1;
            end
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
            shreg   <= shreg << 1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_audio_i2s_tx.sv
// Directed bench for audio_i2s_tx: FIFO model, I2S receiver on rising bclk, word scoreboard.
// Build with I2S_TX_MONO_EN defined to check the mono down-mix expectations.
module tb_audio_i2s_tx;
  import audio_i2s_tx_pkg::*;

  logic        clock, reset;
  logic [31:0] left_audio_in, right_audio_in;
  logic        left_audio_empty, right_audio_empty;
  logic        left_audio_rd_en, right_audio_rd_en;
  logic        bclk, lrclk, sdata;
  logic [15:0] underrun_count;
  i2s_state_t  fsm_state;

  audio_i2s_tx dut (
    .clock(clock), .reset(reset),
    .left_audio_in(left_audio_in), .left_audio_empty(left_audio_empty),
    .left_audio_rd_en(left_audio_rd_en),
    .right_audio_in(right_audio_in), .right_audio_empty(right_audio_empty),
    .right_audio_rd_en(right_audio_rd_en),
    .bclk(bclk), .lrclk(lrclk), .sdata(sdata),
    .underrun_count(underrun_count), .fsm_state(fsm_state)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int pops = 0;
  int bclk_rises = 0;
  int extra_words = 0;
  int rd_mismatch = 0;
  int lr_last = 0;
  int rises_since_fall = 0;
  int last_pop = 0;
  bit lr_seen = 0;
  bit spacing_on = 0;
  bit pop_seen = 0;
  logic prev_lr = 0, prev_bclk = 0, rx_lr = 0;
  logic [15:0] rx_sr = '0;
  logic [31:0] left_q[$];
  logic [31:0] right_q[$];
  logic [15:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] model_sat(input longint v);
    if (v > 32767) return 16'h7FFF;
    if (v < -32768) return 16'h8000;
    return 16'(v);
  endfunction

  task automatic drive_fifo();
    left_audio_empty  = (left_q.size() == 0);
    right_audio_empty = (right_q.size() == 0);
    left_audio_in     = left_audio_empty  ? 32'h0 : left_q[0];
    right_audio_in    = right_audio_empty ? 32'h0 : right_q[0];
  endtask

  task automatic push_pair(input logic [31:0] l, input logic [31:0] r);
    left_q.push_back(l);
    right_q.push_back(r);
    drive_fifo();
  endtask

  task automatic expect_pair(input logic [31:0] l, input logic [31:0] r);
    longint sl, sr;
    sl = longint'($signed(l));
    sr = longint'($signed(r));
`ifdef I2S_TX_MONO_EN
    exp_q.push_back(model_sat((sl + sr) >>> 1));
    exp_q.push_back(model_sat((sl + sr) >>> 1));
`else
    exp_q.push_back(model_sat(sl));
    exp_q.push_back(model_sat(sr));
`endif
  endtask

  // I2S receiver: a word ends on the rising bclk where lrclk differs from the previous bit.
  task automatic sample();
    logic [15:0] e;
    if (left_audio_rd_en !== right_audio_rd_en) rd_mismatch++;
    if (lrclk !== prev_lr) begin
      if (lr_seen) check("lrclk_period", 32'(cyc - lr_last), 32'd64);
      lr_seen = 1;
      lr_last = cyc;
      if (!lrclk) rises_since_fall = 0;
    end
    if (bclk && !prev_bclk) begin
      bclk_rises++;
      rises_since_fall++;
      rx_sr = {rx_sr[14:0], sdata};
      if (lrclk !== rx_lr) begin
        if (exp_q.size() == 0) extra_words++;
        else begin
          e = exp_q.pop_front();
          check(lrclk ? "left_word" : "right_word", 32'(rx_sr), 32'(e));
        end
      end
      rx_lr = lrclk;
    end
    prev_lr   = lrclk;
    prev_bclk = bclk;
  endtask

  task automatic tick();
    logic pend;
    pend = left_audio_rd_en;
    @(posedge clock);
    cyc++;
    if (pend && left_q.size() > 0) begin
      void'(left_q.pop_front());
      void'(right_q.pop_front());
      pops++;
      if (spacing_on && pop_seen) check("rd_en_spacing", 32'(cyc - last_pop), 32'd128);
      pop_seen = 1;
      last_pop = cyc;
    end
    #1;
    drive_fifo();
    sample();
  endtask

  task automatic check_all_zero(input string phase);
    check({phase, "_bclk"}, 32'(bclk), 32'd0);
    check({phase, "_lrclk"}, 32'(lrclk), 32'd0);
    check({phase, "_sdata"}, 32'(sdata), 32'd0);
    check({phase, "_left_rd_en"}, 32'(left_audio_rd_en), 32'd0);
    check({phase, "_right_rd_en"}, 32'(right_audio_rd_en), 32'd0);
    check({phase, "_underrun"}, 32'(underrun_count), 32'd0);
    check({phase, "_state"}, 32'(fsm_state), 32'(IDLE));
  endtask

  initial begin
    int base;
    reset = 1'b0;
    drive_fifo();
    repeat (3) @(posedge clock);
    #1;
    check_all_zero("reset");
    reset = 1'b1;
    repeat (20) tick();
    check("idle_no_bclk", 32'(bclk_rises), 32'd0);
    check("idle_state", 32'(fsm_state), 32'(IDLE));

    // Tests 1-3: a plain pair, a saturating pair, then three empty frames.
    push_pair(32'h0000_1234, 32'hFFFF_EDCC);
    push_pair(32'h0001_2345, 32'hFFF0_0000);
`ifdef I2S_TX_MONO_EN
    exp_q.push_back(16'h0000); exp_q.push_back(16'h0000);
    exp_q.push_back(16'h8000); exp_q.push_back(16'h8000);
`else
    exp_q.push_back(16'h1234); exp_q.push_back(16'hEDCC);
    exp_q.push_back(16'h7FFF); exp_q.push_back(16'h8000);
`endif
    repeat (6) exp_q.push_back(16'h0000);
    for (int g = 0; g < 2000 && underrun_count != 16'd3; g++) tick();
    check("underrun_after_gap", 32'(underrun_count), 32'd3);
    check("zero_words_pending", 32'(exp_q.size()), 32'd2);

    // Test 4: ten pairs stream back to back, one pop per frame.
    base = pops;
    spacing_on = 1;
    pop_seen = 0;
    for (int i = 0; i < 10; i++) begin
      logic [31:0] l, r;
      l = 32'(i) * 32'h1111;
      r = 32'(0 - i * 1000);
      push_pair(l, r);
      expect_pair(l, r);
    end
    for (int g = 0; g < 3000 && exp_q.size() > 0; g++) tick();
    spacing_on = 0;
    check("stream_drained", 32'(exp_q.size()), 32'd0);
    check("stream_pops", 32'(pops - base), 32'd10);
    check("stream_underrun", 32'(underrun_count), 32'd3);

    // Pair captured on the frame-boundary edge: that frame is zero-filled and counted.
    push_pair(32'h0000_35A5, 32'h0000_7FFF);
    exp_q.push_back(16'h0000); exp_q.push_back(16'h0000);
    for (int g = 0; g < 400 && exp_q.size() > 0; g++) tick();
    check("simultaneous_drained", 32'(exp_q.size()), 32'd0);
    check("simultaneous_underrun", 32'(underrun_count), 32'd4);

    // Test 5: reset while bit 7 of the left word is on the line.
    for (int g = 0; g < 200 && rises_since_fall != 10; g++) tick();
    check("bit7_lrclk", 32'(lrclk), 32'd0);
    check("bit7_sdata", 32'(sdata), 32'd1);
`ifdef I2S_TX_MONO_EN
    check("partial_left", 32'(rx_sr[8:0]), 32'h0B5);
`else
    check("partial_left", 32'(rx_sr[8:0]), 32'h06B);
`endif
    #2;
    reset = 1'b0;
    #1;
    check_all_zero("midframe_reset");
    prev_lr = 0; prev_bclk = 0; rx_lr = 0; lr_seen = 0; rises_since_fall = 0;
    tick();
    reset = 1'b1;
    base = bclk_rises;
    repeat (200) tick();
    check("post_reset_no_bclk", 32'(bclk_rises - base), 32'd0);
    check("post_reset_state", 32'(fsm_state), 32'(IDLE));
    check("post_reset_rd_en", 32'(left_audio_rd_en), 32'd0);

    // Test 6: next pair restarts the stream.
    push_pair(32'd1000, 32'd3000);
`ifdef I2S_TX_MONO_EN
    exp_q.push_back(16'h07D0); exp_q.push_back(16'h07D0);
`else
    exp_q.push_back(16'h03E8); exp_q.push_back(16'h0BB8);
`endif
    for (int g = 0; g < 600 && exp_q.size() > 0; g++) tick();
    check("restart_drained", 32'(exp_q.size()), 32'd0);
    check("restart_state", 32'(fsm_state), 32'(RUN));
    check("restart_underrun", 32'(underrun_count), 32'd0);
    check("extra_words", 32'(extra_words), 32'd0);
    check("rd_en_pair_mismatch", 32'(rd_mismatch), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
